// File: rtl/cam_frame_capture.sv
// Camera pixel-clock capture: RGB565 byte pairs -> RGB332, X/Y decimation, frame clipping, linear write addressing.
// Optional build macro CAM_FRAME_CAPTURE_TESTPAT_EN adds TP_SEL and an 8-bar vertical colour test pattern.
module cam_frame_capture #(
  parameter int FRAME_W = 176,
  parameter int FRAME_H = 144,
  parameter int ADDR_W  = 15,
  parameter int DEC_X   = 1,
  parameter int DEC_Y   = 1
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic              CAPTURE_EN,
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
  input  logic              TP_SEL,
`endif
  output logic [7:0]        PIXEL_OUT,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              CLIPPED,
  output logic              ODD_BYTE
);

  localparam int XW = $clog2(FRAME_W + 1);
  localparam int YW = $clog2(FRAME_H + 1);
  localparam logic [XW-1:0]     FW_X   = XW'(FRAME_W);
  localparam logic [YW-1:0]     FH_Y   = YW'(FRAME_H);
  localparam logic [ADDR_W-1:0] FW_A   = ADDR_W'(FRAME_W);
  localparam logic [2:0]        DX_MAX = 3'(DEC_X - 1);
  localparam logic [2:0]        DY_MAX = 3'(DEC_Y - 1);

  typedef enum logic [2:0] {SYNC, VBLANK, LINE_WAIT, ACTIVE, LINE_END, FRAME_END} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                phase_q, phase_d;
  logic [2:0]          decx_q, decx_d;
  logic [2:0]          decy_q, decy_d;
  logic                kept_q, kept_d;
  logic [5:0]          b0_q, b0_d;
  logic                clip_q, clip_d;
  logic                odd_q, odd_d;
  logic                wen_q, wen_d;
  logic [7:0]          pix_q, pix_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                done_q, done_d;
  logic [7:0]          cam_pix;

`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
  localparam int BAR_LEN_I = (FRAME_W / 8 < 1) ? 1 : FRAME_W / 8;
  localparam logic [XW-1:0] BAR_LAST = XW'(BAR_LEN_I - 1);

  logic [2:0]    bar_q, bar_d;
  logic [XW-1:0] bcnt_q, bcnt_d;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h1F;
      3'd3:    c = 8'h1C;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'hE0;
      3'd6:    c = 8'h03;
      default: c = 8'h00;
    endcase
    return c;
  endfunction
`endif

  // b0_q keeps only the R and upper-G bits of the first byte that survive into RGB332.
  assign cam_pix = {b0_q, D[4:3]};

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    phase_d = phase_q;
    decx_d  = decx_q;
    decy_d  = decy_q;
    kept_d  = kept_q;
    b0_d    = b0_q;
    clip_d  = clip_q;
    odd_d   = odd_q;
    wen_d   = 1'b0;
    pix_d   = pix_q;
    waddr_d = waddr_q;
    done_d  = 1'b0;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
    bar_d   = bar_q;
    bcnt_d  = bcnt_q;
`endif
    unique case (state_q)
      SYNC: begin
        if (VSYNC) state_d = VBLANK;
      end
      VBLANK: begin
        if (!VSYNC) begin
          armed_d = CAPTURE_EN;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          clip_d  = 1'b0;
          odd_d   = 1'b0;
          phase_d = 1'b0;
          decx_d  = '0;
          decy_d  = '0;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
          bar_d   = '0;
          bcnt_d  = '0;
`endif
          state_d = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (VSYNC) begin
          state_d = FRAME_END;
        end else if (HREF) begin
          b0_d    = {D[7:5], D[2:0]};
          phase_d = 1'b1;
          kept_d  = (decy_q == '0);
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (VSYNC) begin
          state_d = FRAME_END;
        end else if (!HREF) begin
          state_d = LINE_END;
        end else if (!phase_q) begin
          b0_d    = {D[7:5], D[2:0]};
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          decx_d  = (decx_q == DX_MAX) ? '0 : decx_q + 3'd1;
          if (armed_q && kept_q && decx_q == '0) begin
            if (x_q < FW_X && y_q < FH_Y) begin
              wen_d   = 1'b1;
              waddr_d = base_q + ADDR_W'(x_q);
              x_d     = x_q + 1'b1;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
              pix_d   = TP_SEL ? bar_color(bar_q) : cam_pix;
              if (bcnt_q == BAR_LAST) begin
                bcnt_d = '0;
                bar_d  = bar_q + 3'd1;
              end else begin
                bcnt_d = bcnt_q + 1'b1;
              end
`else
              pix_d   = cam_pix;
`endif
            end else begin
              clip_d = 1'b1;
            end
          end
        end
      end
      LINE_END: begin
        if (phase_q) odd_d = 1'b1;
        if (kept_q) begin
          if (y_q < FH_Y) begin
            y_d    = y_q + 1'b1;
            base_d = base_q + FW_A;
          end else if (armed_q) begin
            clip_d = 1'b1;
          end
        end
        x_d     = '0;
        phase_d = 1'b0;
        decx_d  = '0;
        decy_d  = (decy_q == DY_MAX) ? '0 : decy_q + 3'd1;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
        bar_d   = '0;
        bcnt_d  = '0;
`endif
        state_d = LINE_WAIT;
      end
      FRAME_END: begin
        done_d  = armed_q;
        state_d = VBLANK;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= SYNC;
      armed_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      phase_q <= 1'b0;
      decx_q  <= '0;
      decy_q  <= '0;
      kept_q  <= 1'b0;
      b0_q    <= '0;
      clip_q  <= 1'b0;
      odd_q   <= 1'b0;
      wen_q   <= 1'b0;
      pix_q   <= '0;
      waddr_q <= '0;
      done_q  <= 1'b0;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
      bar_q   <= '0;
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      phase_q <= phase_d;
      decx_q  <= decx_d;
      decy_q  <= decy_d;
      kept_q  <= kept_d;
      b0_q    <= b0_d;
      clip_q  <= clip_d;
      odd_q   <= odd_d;
      wen_q   <= wen_d;
      pix_q   <= pix_d;
      waddr_q <= waddr_d;
      done_q  <= done_d;
`ifdef CAM_FRAME_CAPTURE_TESTPAT_EN
      bar_q   <= bar_d;
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign PIXEL_OUT  = pix_q;
  assign W_ADDR     = waddr_q;
  assign W_EN       = wen_q;
  assign FRAME_DONE = done_q;
  assign CLIPPED    = clip_q;
  assign ODD_BYTE   = odd_q;

endmodule
